// File: rtl/trace_chk_pkg.sv
// rtl/trace_chk_pkg.sv - shared types and constants for the golden-trace checker
//
// Contents:
//   state_e        checker state (LOAD, RUN, PASS, FAIL)
//   FC_*           fail-code values driven on fail_code
//   trace_entry_t  one golden entry: kind, pc, addr, data (97 bits)
//   entry_mismatch compares one observed commit event against one golden entry
package trace_chk_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    localparam logic [2:0] FC_NONE    = 3'd0;
    localparam logic [2:0] FC_KIND    = 3'd1;
    localparam logic [2:0] FC_PC      = 3'd2;
    localparam logic [2:0] FC_ADDR    = 3'd3;
    localparam logic [2:0] FC_DATA    = 3'd4;
    localparam logic [2:0] FC_EXTRA   = 3'd5;
    localparam logic [2:0] FC_TIMEOUT = 3'd6;
    localparam logic [2:0] FC_PROTO   = 3'd7;

    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trace_entry_t;

    // Returns the highest-priority mismatch (KIND > PC > ADDR > DATA), or
    // FC_NONE. For a register commit only addr[4:0] is meaningful (rd index).
    function automatic logic [2:0] entry_mismatch(
        input trace_entry_t e,
        input logic         ev_is_mem,
        input logic [31:0]  pc,
        input logic [4:0]   rd,
        input logic [31:0]  reg_wdata,
        input logic [31:0]  mem_addr,
        input logic [31:0]  mem_wdata
    );
        logic [2:0] code;
        code = FC_NONE;
        if (e.kind != ev_is_mem) begin
            code = FC_KIND;
        end else if (e.pc != pc) begin
            code = FC_PC;
        end else if (ev_is_mem) begin
            if (e.addr != mem_addr) begin
                code = FC_ADDR;
            end else if (e.data != mem_wdata) begin
                code = FC_DATA;
            end
        end else begin
            if (e.addr[4:0] != rd) begin
                code = FC_ADDR;
            end else if (e.data != reg_wdata) begin
                code = FC_DATA;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/trace_store.sv
// rtl/trace_store.sv - golden trace entry storage, synchronous write / asynchronous read
//
// Ports:
//   clk      rising-edge clock
//   we_i     write enable
//   waddr_i  write index
//   wdata_i  entry written at waddr_i
//   raddr_i  read index
//   rdata_o  entry at raddr_i (combinational)
//
// Contents are intentionally not reset; the checker's fill count decides
// which entries are valid.
module trace_store
    import trace_chk_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         we_i,
    input  logic [AW-1:0] waddr_i,
    input  trace_entry_t wdata_i,
    input  logic [AW-1:0] raddr_i,
    output trace_entry_t rdata_o
);

    trace_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/trace_checker.sv
// rtl/trace_checker.sv - compares a DUT commit stream against a preloaded golden trace
//
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   load_valid/load_ready      golden entry handshake (LOAD state only)
//   load_kind/pc/addr/data     golden entry fields
//   start                      pulse: LOAD -> RUN
//   reg_we, rd, reg_wdata      observed register commit
//   mem_we, mem_addr, mem_wdata observed store
//   commit_pc                  PC of the observed commit
//   done, pass                 verdict flags
//   fail_code                  reason for FAIL (trace_chk_pkg FC_*)
//   match_count                entries matched so far
//   fail_index                 entry index blamed on failure
module trace_checker
    import trace_chk_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int MAX_CYCLES = 2000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic                       load_kind,
    input  logic [31:0]                load_pc,
    input  logic [31:0]                load_addr,
    input  logic [31:0]                load_data,
    input  logic                       start,
    input  logic                       reg_we,
    input  logic                       mem_we,
    input  logic [31:0]                commit_pc,
    input  logic [4:0]                 rd,
    input  logic [31:0]                reg_wdata,
    input  logic [31:0]                mem_addr,
    input  logic [31:0]                mem_wdata,
    output logic                       done,
    output logic                       pass,
    output logic [2:0]                 fail_code,
    output logic [$clog2(DEPTH):0]     match_count,
    output logic [$clog2(DEPTH)-1:0]   fail_index
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int CYW = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
    localparam logic [CYW-1:0] CYC_MAX  = CYW'(MAX_CYCLES);
    localparam logic [CYW-1:0] CYC_LAST = CYW'(MAX_CYCLES - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    // The read pointer is the match count: each match consumes exactly one entry.
    logic [CW-1:0]   match_q, match_d;
    logic [CYW-1:0]  cyc_q, cyc_d;
    logic [2:0]      fail_code_q, fail_code_d;
    logic [AW-1:0]   fail_index_q, fail_index_d;
    logic            load_ready_q, load_ready_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;

    logic            accept;
    logic            event_any;
    logic            event_both;
    logic [2:0]      mismatch;
    trace_entry_t    wr_entry;
    trace_entry_t    rd_entry;

    // load_ready_q is only ever high in LOAD with room left, so it fully
    // qualifies the handshake.
    assign accept     = load_valid && load_ready_q;
    assign event_any  = reg_we || mem_we;
    assign event_both = reg_we && mem_we;

    assign wr_entry = '{kind: load_kind, pc: load_pc, addr: load_addr, data: load_data};

    trace_store #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_store (
        .clk     (clk),
        .we_i    (accept),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i (wr_entry),
        .raddr_i (match_q[AW-1:0]),
        .rdata_o (rd_entry)
    );

    assign mismatch = entry_mismatch(rd_entry, mem_we, commit_pc, rd,
                                     reg_wdata, mem_addr, mem_wdata);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        match_d      = match_q;
        cyc_d        = cyc_q;
        fail_code_d  = fail_code_q;
        fail_index_d = fail_index_q;

        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    count_d = count_q + CW'(1);
                end
                // An entry handed over in the same cycle as start still counts.
                if (start) begin
                    if (count_d == '0) begin
                        state_d      = ST_FAIL;
                        fail_code_d  = FC_PROTO;
                        fail_index_d = '0;
                    end else begin
                        state_d = ST_RUN;
                        match_d = '0;
                        cyc_d   = '0;
                    end
                end
            end

            ST_RUN: begin
                if (cyc_q != CYC_MAX) begin
                    cyc_d = cyc_q + CYW'(1);
                end
                if (event_both) begin
                    state_d      = ST_FAIL;
                    fail_code_d  = FC_PROTO;
                    fail_index_d = match_q[AW-1:0];
                end else if (event_any) begin
                    if (mismatch != FC_NONE) begin
                        state_d      = ST_FAIL;
                        fail_code_d  = mismatch;
                        fail_index_d = match_q[AW-1:0];
                    end else begin
                        match_d = match_q + CW'(1);
                        if (match_q == count_q - CW'(1)) begin
                            state_d = ST_PASS;
                        end
                    end
                end else if (cyc_q >= CYC_LAST) begin
                    // The budget covers MAX_CYCLES RUN cycles; an event in the
                    // final one is still honoured above.
                    state_d      = ST_FAIL;
                    fail_code_d  = FC_TIMEOUT;
                    fail_index_d = match_q[AW-1:0];
                end
            end

            ST_PASS: begin
                if (event_any) begin
                    state_d      = ST_FAIL;
                    fail_code_d  = FC_EXTRA;
                    fail_index_d = count_q[AW-1:0];
                end
            end

            default: begin
                state_d = ST_FAIL;
            end
        endcase

        load_ready_d = (state_d == ST_LOAD) && (count_d < DEPTH_C);
        done_d       = (state_d == ST_PASS) || (state_d == ST_FAIL);
        pass_d       = (state_d == ST_PASS);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_LOAD;
            count_q      <= '0;
            match_q      <= '0;
            cyc_q        <= '0;
            fail_code_q  <= FC_NONE;
            fail_index_q <= '0;
            load_ready_q <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            match_q      <= match_d;
            cyc_q        <= cyc_d;
            fail_code_q  <= fail_code_d;
            fail_index_q <= fail_index_d;
            load_ready_q <= load_ready_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign load_ready  = load_ready_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_code   = fail_code_q;
    assign match_count = match_q;
    assign fail_index  = fail_index_q;

endmodule

// File: tb/tb_trace_checker.sv
// tb/tb_trace_checker.sv - directed self-checking bench for trace_checker
module tb_trace_checker;

    localparam int DEPTH = 64;
    localparam int MAXC  = 2000;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic        load_kind;
    logic [31:0] load_pc;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        start;
    logic        reg_we;
    logic        mem_we;
    logic [31:0] commit_pc;
    logic [4:0]  rd;
    logic [31:0] reg_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        done;
    logic        pass;
    logic [2:0]  fail_code;
    logic [6:0]  match_count;
    logic [5:0]  fail_index;

    int errors = 0;
    int checks = 0;

    trace_checker #(.DEPTH(DEPTH), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_kind(load_kind), .load_pc(load_pc), .load_addr(load_addr), .load_data(load_data),
        .start(start), .reg_we(reg_we), .mem_we(mem_we), .commit_pc(commit_pc),
        .rd(rd), .reg_wdata(reg_wdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .done(done), .pass(pass), .fail_code(fail_code),
        .match_count(match_count), .fail_index(fail_index)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        load_valid = 0; load_kind = 0; load_pc = 0; load_addr = 0; load_data = 0;
        start = 0; reg_we = 0; mem_we = 0; commit_pc = 0; rd = 0;
        reg_wdata = 0; mem_addr = 0; mem_wdata = 0;
        reset = 0;
        tick();
        tick();
        reset = 1;
    endtask

    task automatic load_entry(input logic k, input logic [31:0] p, input logic [31:0] a, input logic [31:0] d);
        load_valid = 1; load_kind = k; load_pc = p; load_addr = a; load_data = d;
        tick();
        load_valid = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic reg_event(input logic [31:0] p, input logic [4:0] r, input logic [31:0] d);
        reg_we = 1; commit_pc = p; rd = r; reg_wdata = d;
        tick();
        reg_we = 0;
    endtask

    task automatic mem_event(input logic [31:0] p, input logic [31:0] a, input logic [31:0] d);
        mem_we = 1; commit_pc = p; mem_addr = a; mem_wdata = d;
        tick();
        mem_we = 0;
    endtask

    task automatic load_three();
        load_entry(0, 32'h0, 32'd5, 32'd10);
        load_entry(1, 32'h4, 32'h100, 32'd7);
        load_entry(0, 32'h8, 32'd6, 32'd17);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got=%0d exp=1", load_ready); end
        checks++; if ({done, pass, fail_code} !== 5'b00_000) begin errors++; $display("FAIL reset_status got=%b exp=00000", {done, pass, fail_code}); end
        checks++; if (match_count !== 7'd0) begin errors++; $display("FAIL reset_match got=%0d exp=0", match_count); end
        checks++; if (fail_index !== 6'd0) begin errors++; $display("FAIL reset_fail_index got=%0d exp=0", fail_index); end
    endtask

    task automatic test_pass();
        do_reset();
        load_three();
        pulse_start();
        checks++; if ({load_ready, done} !== 2'b00) begin errors++; $display("FAIL pass_run_flags got=%b exp=00", {load_ready, done}); end
        reg_event(32'h0, 5'd5, 32'd10);
        mem_event(32'h4, 32'h100, 32'd7);
        checks++; if ({done, match_count} !== {1'b0, 7'd2}) begin errors++; $display("FAIL pass_mid got=%0d/%0d exp=0/2", done, match_count); end
        reg_event(32'h8, 5'd6, 32'd17);
        checks++; if ({done, pass, fail_code} !== 5'b11_000) begin errors++; $display("FAIL pass_status got=%b exp=11000", {done, pass, fail_code}); end
        checks++; if (match_count !== 7'd3) begin errors++; $display("FAIL pass_match got=%0d exp=3", match_count); end
    endtask

    task automatic test_data_mismatch();
        do_reset();
        load_three();
        pulse_start();
        reg_event(32'h0, 5'd5, 32'd10);
        mem_event(32'h4, 32'h100, 32'd8);
        checks++; if ({done, pass, fail_code} !== 5'b10_100) begin errors++; $display("FAIL data_status got=%b exp=10100", {done, pass, fail_code}); end
        checks++; if ({fail_index, match_count} !== {6'd1, 7'd1}) begin errors++; $display("FAIL data_idx_match got=%0d/%0d exp=1/1", fail_index, match_count); end
        reg_event(32'h8, 5'd6, 32'd17);
        pulse_start();
        checks++; if ({done, fail_code, match_count} !== {1'b1, 3'd4, 7'd1}) begin errors++; $display("FAIL data_terminal got=%0d/%0d/%0d exp=1/4/1", done, fail_code, match_count); end
    endtask

    task automatic test_priority();
        logic [2:0] exp_code;
        for (int i = 0; i < 4; i++) begin
            do_reset();
            load_three();
            pulse_start();
            case (i)
                0: begin mem_event(32'h8, 32'h100, 32'd10); exp_code = 3'd1; end
                1: begin reg_event(32'h4, 5'd6, 32'd11);    exp_code = 3'd2; end
                2: begin reg_event(32'h0, 5'd6, 32'd11);    exp_code = 3'd3; end
                default: begin reg_event(32'h0, 5'd5, 32'd11); exp_code = 3'd4; end
            endcase
            checks++; if ({done, fail_code, fail_index, match_count} !== {1'b1, exp_code, 6'd0, 7'd0}) begin errors++; $display("FAIL priority_%0d got=%0d/%0d/%0d/%0d exp=1/%0d/0/0", i, done, fail_code, fail_index, match_count, exp_code); end
        end
    endtask

    task automatic test_extra();
        do_reset();
        load_entry(0, 32'h20, 32'hABCD_0005, 32'd99);
        pulse_start();
        reg_event(32'h20, 5'd5, 32'd99);
        checks++; if ({done, pass, match_count} !== {2'b11, 7'd1}) begin errors++; $display("FAIL extra_pass got=%0d/%0d/%0d exp=1/1/1", done, pass, match_count); end
        reg_event(32'h24, 5'd1, 32'd0);
        checks++; if ({done, pass, fail_code} !== 5'b10_101) begin errors++; $display("FAIL extra_status got=%b exp=10101", {done, pass, fail_code}); end
        checks++; if ({fail_index, match_count} !== {6'd1, 7'd1}) begin errors++; $display("FAIL extra_idx got=%0d/%0d exp=1/1", fail_index, match_count); end
    endtask

    task automatic test_timeout();
        do_reset();
        load_entry(0, 32'h0, 32'd1, 32'd1);
        load_entry(0, 32'h4, 32'd2, 32'd2);
        pulse_start();
        repeat (MAXC - 1) tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL timeout_early got=%0d exp=0", done); end
        tick();
        checks++; if ({done, pass, fail_code, fail_index} !== {2'b10, 3'd6, 6'd0}) begin errors++; $display("FAIL timeout_status got=%0d/%0d/%0d/%0d exp=1/0/6/0", done, pass, fail_code, fail_index); end

        do_reset();
        load_entry(0, 32'h0, 32'd1, 32'd1);
        load_entry(0, 32'h4, 32'd2, 32'd2);
        pulse_start();
        repeat (MAXC - 1) tick();
        reg_event(32'h0, 5'd1, 32'd1);
        checks++; if ({done, match_count} !== {1'b0, 7'd1}) begin errors++; $display("FAIL timeout_event_wins got=%0d/%0d exp=0/1", done, match_count); end
        tick();
        checks++; if ({done, fail_code, fail_index} !== {1'b1, 3'd6, 6'd1}) begin errors++; $display("FAIL timeout_after got=%0d/%0d/%0d exp=1/6/1", done, fail_code, fail_index); end

        do_reset();
        pulse_start();
        checks++; if ({done, pass, fail_code, fail_index, load_ready} !== {2'b10, 3'd7, 6'd0, 1'b0}) begin errors++; $display("FAIL proto_empty got=%0d/%0d/%0d/%0d/%0d exp=1/0/7/0/0", done, pass, fail_code, fail_index, load_ready); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) begin
                checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_63 got=%0d exp=1", load_ready); end
            end
            load_entry(0, 32'(i * 4), 32'(i % 32), 32'(i * 3 + 1));
        end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_full got=%0d exp=0", load_ready); end
        load_entry(0, 32'h0, 32'd0, 32'hDEAD);
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            reg_event(32'(i * 4), 5'(i % 32), 32'(i * 3 + 1));
        end
        checks++; if ({done, pass, fail_code, match_count} !== {2'b11, 3'd0, 7'd64}) begin errors++; $display("FAIL fill_pass got=%0d/%0d/%0d/%0d exp=1/1/0/64", done, pass, fail_code, match_count); end
        mem_event(32'h0, 32'h0, 32'h0);
        checks++; if ({fail_code, fail_index} !== {3'd5, 6'd0}) begin errors++; $display("FAIL fill_extra got=%0d/%0d exp=5/0", fail_code, fail_index); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        load_three();
        pulse_start();
        reg_we = 1; mem_we = 1; commit_pc = 0; rd = 5; reg_wdata = 10; mem_addr = 32'h100; mem_wdata = 7;
        tick();
        reg_we = 0; mem_we = 0;
        checks++; if ({done, fail_code, fail_index, match_count} !== {1'b1, 3'd7, 6'd0, 7'd0}) begin errors++; $display("FAIL both_we got=%0d/%0d/%0d/%0d exp=1/7/0/0", done, fail_code, fail_index, match_count); end

        do_reset();
        load_three();
        pulse_start();
        reg_event(32'h0, 5'd5, 32'd10);
        reset = 0;
        tick();
        reset = 1;
        checks++; if ({load_ready, done, pass, fail_code, match_count} !== {3'b100, 3'd0, 7'd0}) begin errors++; $display("FAIL midrun_reset got=%0d/%0d/%0d/%0d/%0d exp=1/0/0/0/0", load_ready, done, pass, fail_code, match_count); end
        pulse_start();
        checks++; if ({done, fail_code} !== {1'b1, 3'd7}) begin errors++; $display("FAIL midrun_discard got=%0d/%0d exp=1/7", done, fail_code); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_data_mismatch();
        test_priority();
        test_extra();
        test_timeout();
        test_fill();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trace_checker.md
TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of golden trace entries stored (power of two).
REQ-002 SHALL have parameter MAX_CYCLES, default 2000, RUN-state cycle budget before timeout.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 load_valid  input  1  golden entry offered.
REQ-006 load_ready  output  1  entry accepted when load_valid && load_ready.
REQ-007 load_kind  input  1  0 = REG commit, 1 = MEM store.
REQ-008 load_pc  input  32  expected commit PC.
REQ-009 load_addr  input  32  REG: rd index in [4:0]; MEM: byte address.
REQ-010 load_data  input  32  expected write data.
REQ-011 start  input  1  one-cycle pulse, LOAD -> RUN.
REQ-012 reg_we  input  1  DUT register write this cycle.
REQ-013 mem_we  input  1  DUT store this cycle.
REQ-014 commit_pc  input  32  PC of committing instruction.
REQ-015 rd  input  5  destination register index.
REQ-016 reg_wdata  input  32  write-back value.
REQ-017 mem_addr  input  32  store address.
REQ-018 mem_wdata  input  32  store data.
REQ-019 done  output  1  checker in PASS or FAIL.
REQ-020 pass  output  1  checker in PASS.
REQ-021 fail_code  output  3  0 NONE, 1 KIND, 2 PC, 3 ADDR, 4 DATA, 5 EXTRA, 6 TIMEOUT, 7 PROTO.
REQ-022 match_count  output  $clog2(DEPTH)+1  entries matched so far.
REQ-023 fail_index  output  $clog2(DEPTH)  entry index at failure.

Function
REQ-024 States LOAD, RUN, PASS, FAIL; all outputs registered.
REQ-025 LOAD: load_ready = 1 while fill count < DEPTH; each handshake writes entry at write pointer, count++.
REQ-026 load_ready SHALL be 0 when count == DEPTH and in every non-LOAD state; load_valid then ignored.
REQ-027 start in LOAD with count == 0 -> FAIL, code PROTO; with count > 0 -> RUN, read pointer 0, cycle counter 0.
REQ-028 RUN event = reg_we or mem_we; compare against entry at read pointer same cycle, result registered at that edge.
REQ-029 REG compare: kind 0, pc, addr[4:0] vs rd, data vs reg_wdata; MEM compare: kind 1, pc, addr vs mem_addr, data vs mem_wdata.
REQ-030 Mismatch priority KIND > PC > ADDR > DATA; first mismatch -> FAIL, fail_index = read pointer, match_count frozen.
REQ-031 Match -> read pointer++, match_count++; match of last entry (read pointer == count-1) -> PASS next cycle.
REQ-032 reg_we && mem_we same cycle in RUN -> FAIL, code PROTO, no entry consumed.
REQ-033 Any event while in PASS -> FAIL, code EXTRA, fail_index = count mod DEPTH.
REQ-034 RUN cycle counter reaching MAX_CYCLES with no event that cycle -> FAIL, code TIMEOUT; an event in that cycle takes precedence.
REQ-035 FAIL is terminal until reset; events and start ignored; start in RUN/PASS ignored.
REQ-036 Load of exactly DEPTH entries SHALL be legal; count holds DEPTH without wrap.

Reset
REQ-037 reset low at rising edge: state LOAD, pointers/count/cycle counter 0, load_ready 1, done 0, pass 0, fail_code 0, match_count 0, fail_index 0; storage contents not cleared.
REQ-038 Reset mid-RUN SHALL discard all loaded entries (count = 0).

Structure
REQ-039 Package trace_chk_pkg SHALL hold state enum, fail-code constants, and trace-entry struct (kind, pc, addr, data; 97 bits).
REQ-040 Entry storage SHALL be sub-module trace_store (sync write, async read, DEPTH x 97); control FSM in trace_checker.

Verification
REQ-041 Load 3 entries {REG pc 0 x5 10},{MEM pc 4 0x100 7},{REG pc 8 x6 17}, start, matching events -> pass = 1, match_count 3, fail_code 0.
REQ-042 Same load, 2nd event mem_wdata = 8 -> FAIL, code DATA, fail_index 1, match_count 1.
REQ-043 Load 1 entry, start, matching event, then another reg_we -> PASS then FAIL, code EXTRA.
REQ-044 Load 2 entries, start, no events for MAX_CYCLES -> FAIL, code TIMEOUT; start with 0 entries -> PROTO.
REQ-045 Fill DEPTH entries -> load_ready drops after 64th handshake; 65th offer ignored, count 64.
REQ-046 reg_we and mem_we together in RUN -> FAIL, code PROTO; reset low mid-RUN -> LOAD, count 0.
